// File: rtl/inst_mem_boot.sv
// Loadable, RAM-backed instruction memory for the IF stage: a boot loader fills it in LOAD,
// the core reads it with one cycle of latency in RUN. Define IMEM_PARITY_EN for per-word parity.
module inst_mem_boot #(
    parameter int                IDX_W    = 8,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_en,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_par,
    input  logic              load_last,
    input  logic              reload,
    output logic [IDX_W:0]    load_count,
    output logic              boot_done,
    output logic              parity_err
);

    localparam int             DEPTH     = 2 ** IDX_W;
    localparam logic [IDX_W:0] COUNT_MAX = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  fetch_idx;
    logic              addr_bad;
    logic              load_fire;
    logic              fetch_par_err;

    // Loader handshake: a word transfers on any edge where load_valid and load_ready are both
    // high; load_ready is high exactly while in LOAD, so the loader may hold load_valid freely.
    assign load_fire = load_valid && load_ready && (state == LOAD);
    assign fetch_idx = fetch_addr[IDX_W+1:2];
    assign addr_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:IDX_W+2] != '0);

    // The array is deliberately not reset so an image survives a core reset.
    always_ff @(posedge clk) begin
        if (reset && load_fire) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset && load_fire) begin
            par_mem[load_addr] <= load_par;
        end
    end

    assign fetch_par_err = ^{mem[fetch_idx], par_mem[fetch_idx]};
`else
    logic unused_par;

    assign unused_par    = load_par;
    assign fetch_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= LOAD;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            parity_err  <= 1'b0;
            load_count  <= '0;
            boot_done   <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    instr       <= NOP_WORD;
                    instr_valid <= 1'b0;
                    addr_err    <= 1'b0;
                    parity_err  <= 1'b0;
                    if (load_fire) begin
                        if (load_count != COUNT_MAX) begin
                            load_count <= load_count + 1'b1;
                        end
                        if (load_last) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            boot_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        state       <= LOAD;
                        load_ready  <= 1'b1;
                        boot_done   <= 1'b0;
                        load_count  <= '0;
                        instr       <= NOP_WORD;
                        instr_valid <= 1'b0;
                        addr_err    <= 1'b0;
                        parity_err  <= 1'b0;
                    end else if (stall) begin
                        // hazard unit freezes IF: every output register keeps its value
                    end else if (fetch_en) begin
                        if (addr_bad) begin
                            instr       <= NOP_WORD;
                            instr_valid <= 1'b0;
                            addr_err    <= 1'b1;
                            parity_err  <= 1'b0;
                        end else begin
                            instr       <= mem[fetch_idx];
                            instr_valid <= 1'b1;
                            addr_err    <= 1'b0;
                            parity_err  <= fetch_par_err;
                        end
                    end else begin
                        instr       <= NOP_WORD;
                        instr_valid <= 1'b0;
                        addr_err    <= 1'b0;
                        parity_err  <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_boot.sv
// Scoreboard bench for inst_mem_boot: an array-based model predicts every post-edge output,
// a negedge monitor compares. Define IMEM_PARITY_EN here too when the RTL is built with it.
module tb_inst_mem_boot;

    localparam int IDX_W = 8;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int W     = 46;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        addr_err;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        load_par;
    logic        load_last;
    logic        reload;
    logic [8:0]  load_count;
    logic        boot_done;
    logic        parity_err;

    inst_mem_boot #(.IDX_W(IDX_W), .DATA_W(32), .NOP_WORD(32'h0)) dut (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_en(fetch_en),
        .stall(stall), .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data), .load_par(load_par), .load_last(load_last),
        .reload(reload), .load_count(load_count), .boot_done(boot_done),
        .parity_err(parity_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    logic        m_par [DEPTH];
    bit          m_run;
    int          m_count;
    logic [31:0] m_instr;
    logic        m_valid, m_aerr, m_perr;

    logic [W-1:0] exp_q[$];
    int           loaded_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic model_clear_out();
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_aerr  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        int          i;
        if (!reset) begin
            m_run   = 0;
            m_count = 0;
            model_clear_out();
        end else if (!m_run) begin
            model_clear_out();
            if (load_valid) begin
                m_mem[load_addr] = load_data;
                m_par[load_addr] = load_par;
                if (m_count < DEPTH) m_count++;
                if (load_last) m_run = 1;
            end
        end else if (reload) begin
            m_run   = 0;
            m_count = 0;
            model_clear_out();
        end else if (stall) begin
            // outputs unchanged
        end else if (fetch_en) begin
            if ((fetch_addr % 4) != 0 || fetch_addr >= 32'(4 * DEPTH)) begin
                model_clear_out();
                m_aerr = 1'b1;
            end else begin
                i       = int'(fetch_addr / 4);
                w       = m_mem[i];
                m_instr = w;
                m_valid = 1'b1;
                m_aerr  = 1'b0;
`ifdef IMEM_PARITY_EN
                m_perr  = (^w) ^ m_par[i];
`else
                m_perr  = 1'b0;
`endif
            end
        end else begin
            model_clear_out();
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_step();
        exp_q.push_back({m_instr, m_valid, m_aerr, m_perr, 9'(m_count), m_run, !m_run});
        #1;
    endtask

    task automatic set_idle();
        fetch_en = 0; stall = 0; reload = 0; fetch_addr = 32'h0;
        load_valid = 0; load_last = 0; load_par = 0; load_addr = 8'h0; load_data = 32'h0;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d, input logic p, input logic last);
        load_valid = 1; load_addr = 8'(idx); load_data = d; load_par = p; load_last = last;
        tick();
        load_valid = 0; load_last = 0;
        loaded_q.push_back(idx);
    endtask

    task automatic fetch(input logic [31:0] a, input logic st);
        fetch_en = 1; fetch_addr = a; stall = st;
        tick();
        fetch_en = 0; stall = 0;
    endtask

    task automatic load_image(input int n);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            load_word($urandom_range(0, DEPTH - 1), d, 1'($urandom_range(0, 1)), k == n - 1);
        end
    endtask

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr",       instr,              e[45:14]);
            check("instr_valid", 32'(instr_valid),   32'(e[13]));
            check("addr_err",    32'(addr_err),      32'(e[12]));
            check("parity_err",  32'(parity_err),    32'(e[11]));
            check("load_count",  32'(load_count),    32'(e[10:2]));
            check("boot_done",   32'(boot_done),     32'(e[1]));
            check("load_ready",  32'(load_ready),    32'(e[0]));
        end
    end

    // stimulus
    initial begin
        int r;
        set_idle();
        reset = 0;
        tick();
        tick();
        reset = 1;

        // boot image, last word on index 3
        load_word(0, 32'h0800_0010, ^32'h0800_0010, 0);
        load_word(1, 32'h3C0D_4000, ^32'h3C0D_4000, 0);
        load_word(2, 32'h0000_0000, 1'b0, 0);
        load_word(3, 32'h0800_001A, ^32'h0800_001A, 1);
        tick();

        fetch(32'h4, 0);
        for (int k = 0; k < 3; k++) fetch(32'h8, 1);
        fetch(32'h8, 0);
        fetch(32'h0, 0);
        fetch(32'h6, 0);
        fetch(32'h400, 0);
        fetch(32'hC, 0);
        tick();

        // reload wins over a same-edge fetch; parity words; reset in the middle of loading
        fetch_en = 1; fetch_addr = 32'h4; reload = 1;
        tick();
        set_idle();
        load_word(4, 32'h0000_0001, 1'b0, 0);
        load_word(5, 32'h0000_0001, 1'b1, 0);
        reset = 0;
        tick();
        reset = 1;
        load_word(6, 32'h0000_1234, ^32'h0000_1234, 1);
        fetch(32'h10, 0);
        fetch(32'h14, 0);
        for (int a = 0; a < 28; a += 4) fetch(32'(a), 0);

        // count saturates at DEPTH
        fetch_en = 1; reload = 1;
        tick();
        set_idle();
        load_image(DEPTH + 3);

        // randomized RUN traffic with occasional reload and reset
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reload = 1; fetch_en = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
                tick();
                set_idle();
                load_image($urandom_range(1, 8));
            end else if (r < 3) begin
                reset = 0; fetch_en = 1; load_valid = 1'($urandom_range(0, 1));
                tick();
                reset = 1;
                set_idle();
                load_image($urandom_range(1, 8));
            end else begin
                stall      = ($urandom_range(0, 4) == 0);
                fetch_en   = ($urandom_range(0, 9) < 7);
                load_valid = 1'($urandom_range(0, 1));
                load_last  = 1'($urandom_range(0, 1));
                load_addr  = 8'($urandom_range(0, DEPTH - 1));
                load_data  = $urandom;
                r = $urandom_range(0, 99);
                if (r < 70)      fetch_addr = 32'(loaded_q[$urandom_range(0, loaded_q.size() - 1)] * 4);
                else if (r < 85) fetch_addr = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1;
                else             fetch_addr = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
                tick();
                set_idle();
            end
        end

        tick();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
